// File: rtl/reg_timeout_guard_pkg.sv
// Shared types and helpers for the register-bus timeout guard.
// Holds the guard FSM encoding, the default regbus request/response
// structs, the default poison read value and the wait-counter width helper.
package reg_timeout_guard_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    // Read data returned upstream when a transfer is aborted.
    localparam logic [31:0] DEF_ERR_DATA = 32'hBADC_AB1E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } guard_state_e;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic                        write;
        logic [DEF_DATA_WIDTH-1:0]   wdata;
        logic [DEF_DATA_WIDTH/8-1:0] wstrb;
        logic                        valid;
    } reg_req_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      ready;
    } reg_rsp_t;

    // Width needed to hold the in-transfer cycle index 0..timeout_cycles.
    function automatic int wait_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/reg_timeout_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module reg_timeout_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE_S = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count up on inc, hold at all-ones, clear wins over a same-cycle inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE_S;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/reg_timeout_guard.sv
// Register-bus timeout guard.
// Passes requests/responses straight through; if the device keeps a request
// waiting for TIMEOUT_CYCLES cycles, the guard spends one cycle answering the
// upstream side itself with error=1 and a poison read value, then releases.
// Optional first-error address capture: define REG_TIMEOUT_GUARD_ADDR_CAPTURE_EN.
module reg_timeout_guard
    import reg_timeout_guard_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA,
    parameter type         reg_req_t      = reg_timeout_guard_pkg::reg_req_t,
    parameter type         reg_rsp_t      = reg_timeout_guard_pkg::reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  reg_req_t              reg_req_i,
    output reg_rsp_t              reg_rsp_o,
    output reg_req_t              reg_req_o,
    input  reg_rsp_t              reg_rsp_i,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  timeout_cnt_o,
    input  logic                  clear_i,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_valid_o
);

    localparam int WAIT_W = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0]     WAIT_ONE_S  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0]     WAIT_LAST_S = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA_S  = DATA_WIDTH'(ERR_DATA);

    guard_state_e      state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_r;
    logic              in_err_s;

    assign in_err_s  = (state_r == ST_ERR);
    assign timeout_o = timeout_r;

    // Guard FSM with inline wait counter; timeout_r is high exactly in ERR.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (reg_req_i.valid && !reg_rsp_i.ready) begin
                        if (TIMEOUT_CYCLES == 1) begin
                            state_r    <= ST_ERR;
                            wait_cnt_r <= '0;
                            timeout_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_BUSY;
                            wait_cnt_r <= WAIT_ONE_S;
                            timeout_r  <= 1'b0;
                        end
                    end else begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= '0;
                        timeout_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (!reg_req_i.valid || reg_rsp_i.ready) begin
                        // Normal completion or upstream withdrew: no timeout.
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= '0;
                        timeout_r  <= 1'b0;
                    end else if (wait_cnt_r == WAIT_LAST_S) begin
                        state_r    <= ST_ERR;
                        wait_cnt_r <= wait_cnt_r;
                        timeout_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_BUSY;
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE_S;
                        timeout_r  <= 1'b0;
                    end
                end
                ST_ERR: begin
                    // Single abort cycle; device response is ignored here.
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= '0;
                    timeout_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= '0;
                    timeout_r  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency pass-through, overridden by the abort response during ERR.
    always_comb begin
        reg_req_o = reg_req_i;
        reg_rsp_o = reg_rsp_i;
        if (in_err_s) begin
            reg_req_o.valid = 1'b0;
            reg_rsp_o.ready = 1'b1;
            reg_rsp_o.error = 1'b1;
            reg_rsp_o.rdata = ERR_DATA_S;
        end else begin
            reg_req_o.valid = reg_req_i.valid;
            reg_rsp_o.ready = reg_rsp_i.ready;
        end
    end

    reg_timeout_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_timeout_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .inc   (in_err_s),
        .count (timeout_cnt_o)
    );

`ifdef REG_TIMEOUT_GUARD_ADDR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] err_addr_r;
    logic                  err_valid_r;

    // Latch the address of the first aborted transfer until cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_r  <= '0;
            err_valid_r <= 1'b0;
        end else if (clear_i) begin
            err_addr_r  <= '0;
            err_valid_r <= 1'b0;
        end else if (in_err_s && !err_valid_r) begin
            err_addr_r  <= reg_req_i.addr;
            err_valid_r <= 1'b1;
        end else begin
            err_addr_r  <= err_addr_r;
            err_valid_r <= err_valid_r;
        end
    end

    assign err_addr_o  = err_addr_r;
    assign err_valid_o = err_valid_r;
`else
    assign err_addr_o  = '0;
    assign err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Scoreboard bench for reg_timeout_guard with TIMEOUT_CYCLES=4, CNT_WIDTH=2.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clear_i;
    reg_req_t    reg_req_i, reg_req_o;
    reg_rsp_t    reg_rsp_i, reg_rsp_o;
    logic        timeout_o;
    logic [1:0]  timeout_cnt_o;
    logic [31:0] err_addr_o;
    logic        err_valid_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    reg_timeout_guard #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .reg_req_i     (reg_req_i),
        .reg_rsp_o     (reg_rsp_o),
        .reg_req_o     (reg_req_o),
        .reg_rsp_i     (reg_rsp_i),
        .timeout_o     (timeout_o),
        .timeout_cnt_o (timeout_cnt_o),
        .clear_i       (clear_i),
        .err_addr_o    (err_addr_o),
        .err_valid_o   (err_valid_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every upstream handshake pops one expected {rdata,error}.
    always @(negedge clk) begin
        if (!rst_i && reg_req_i.valid && reg_rsp_o.ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %0h error %0b with no expected entry",
                         reg_rsp_o.rdata, reg_rsp_o.error);
            end else begin
                chk("rsp_rdata_error", {31'd0, reg_rsp_o.rdata, reg_rsp_o.error}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reg_req_i.valid = 1'b0;
            reg_rsp_i.ready = 1'b0;
            clear_i         = 1'b0;
            @(negedge clk);
        end
    endtask

    // One transfer; ready_at<0 or >=T means the device never answers in time.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int ready_at, input logic [31:0] dev_rdata,
                           input logic late_ready, input logic clr_in_err);
        logic tmo;
        int   done_c;
        tmo    = (ready_at < 0) || (ready_at >= T);
        done_c = tmo ? T : ready_at;
        exp_q.push_back(tmo ? {32'hBADC_AB1E, 1'b1} : {dev_rdata, 1'b0});
        for (int c = 0; c <= done_c; c++) begin
            @(posedge clk); #1;
            reg_req_i.addr  = addr;
            reg_req_i.write = wr;
            reg_req_i.wdata = wdata;
            reg_req_i.wstrb = 4'hF;
            reg_req_i.valid = 1'b1;
            reg_rsp_i.rdata = dev_rdata;
            reg_rsp_i.error = 1'b0;
            reg_rsp_i.ready = (c == ready_at) || (tmo && (c == T) && late_ready);
            clear_i         = clr_in_err && tmo && (c == T);
            @(negedge clk);
            chk("timeout_o", {63'd0, timeout_o}, {63'd0, (tmo && (c == T))});
            chk("req_o_valid", {63'd0, reg_req_o.valid}, {63'd0, !(tmo && (c == T))});
            if (c == 0) begin
                chk("req_o_addr", {32'd0, reg_req_o.addr}, {32'd0, addr});
            end
        end
    endtask

    task automatic chk_cnt(input logic [1:0] exp_cnt, input logic [31:0] exp_addr, input logic exp_v);
        chk("timeout_cnt", {62'd0, timeout_cnt_o}, {62'd0, exp_cnt});
`ifdef REG_TIMEOUT_GUARD_ADDR_CAPTURE_EN
        chk("err_addr", {32'd0, err_addr_o}, {32'd0, exp_addr});
        chk("err_valid", {63'd0, err_valid_o}, {63'd0, exp_v});
`else
        chk("err_addr", {32'd0, err_addr_o}, 64'd0);
        chk("err_valid", {63'd0, err_valid_o}, 64'd0);
        if (exp_v === 1'bx) $display("note: %0h", exp_addr);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i     = 1'b1;
        clear_i   = 1'b0;
        reg_req_i = '0;
        reg_rsp_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_timeout_o", {63'd0, timeout_o}, 64'd0);
        chk("reset_rsp_ready", {63'd0, reg_rsp_o.ready}, 64'd0);
        chk_cnt(2'd0, 32'h0, 1'b0);

        // Immediate device ready.
        run_txn(32'h10, 1'b0, 32'h0, 0, 32'h0000_1234, 1'b0, 1'b0);
        // Write completes at c=3, one short of timing out.
        run_txn(32'h20, 1'b1, 32'hCAFE_0001, 3, 32'h0, 1'b0, 1'b0);
        idle(1);
        chk_cnt(2'd0, 32'h0, 1'b0);

        // Device never ready, late ready in ERR, then back-to-back 0x40.
        run_txn(32'h30, 1'b0, 32'h0, -1, 32'h5555_AAAA, 1'b1, 1'b0);
        run_txn(32'h40, 1'b0, 32'h0, 2, 32'h0000_0040, 1'b0, 1'b0);
        idle(1);
        chk_cnt(2'd1, 32'h30, 1'b1);

        // Five timeouts: saturate at 3, capture keeps the first address.
        for (int i = 0; i < 5; i++) begin
            run_txn(32'h50 + 32'(i * 16), 1'b0, 32'h0, -1, 32'h0, 1'b0, 1'b0);
            idle(1);
            chk_cnt((i >= 1) ? 2'd3 : 2'd2, 32'h30, 1'b1);
        end

        // Clear coinciding with an ERR increment and capture: clear wins.
        run_txn(32'hA0, 1'b0, 32'h0, -1, 32'h0, 1'b0, 1'b1);
        idle(1);
        chk_cnt(2'd0, 32'h0, 1'b0);

        // Fresh capture after clear, then a standalone clear pulse.
        run_txn(32'hC0, 1'b0, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        idle(1);
        chk_cnt(2'd1, 32'hC0, 1'b1);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        @(negedge clk);
        chk_cnt(2'd0, 32'h0, 1'b0);

        // Get a non-zero count, then reset in the middle of a stalled read.
        run_txn(32'hD0, 1'b0, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        idle(1);
        chk_cnt(2'd1, 32'hD0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            reg_req_i.addr  = 32'hE0;
            reg_req_i.valid = 1'b1;
            reg_rsp_i.ready = 1'b0;
            rst_i           = (c == 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst_i           = 1'b0;
        reg_req_i.valid = 1'b0;
        @(negedge clk);
        chk_cnt(2'd0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("post_reset_timeout_o", {63'd0, timeout_o}, 64'd0);
        end
        run_txn(32'hF0, 1'b0, 32'h0, 1, 32'h0000_00F0, 1'b0, 1'b0);
        idle(2);
        chk_cnt(2'd0, 32'h0, 1'b0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
